// File: rtl/score_keeper_if.sv
// Control pulses in, score digits / blank / state flags out, between game logic and the SSD mux.
// Best_* carry the best score only when SCORE_BEST_EN is defined; otherwise they read 0.
interface score_keeper_if;
    logic       Start;
    logic       Ack;
    logic       Pass;
    logic       Lose;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       Blank;
    logic       Q_Idle;
    logic       Q_Play;
    logic       Q_Over;
    logic [3:0] Best_Tens;
    logic [3:0] Best_Ones;

    modport master (
        output Start, Ack, Pass, Lose,
        input  Tens, Ones, Blank, Q_Idle, Q_Play, Q_Over, Best_Tens, Best_Ones
    );

    modport slave (
        input  Start, Ack, Pass, Lose,
        output Tens, Ones, Blank, Q_Idle, Q_Play, Q_Over, Best_Tens, Best_Ones
    );
endinterface

// File: rtl/score_keeper.sv
// Two-digit BCD score counter with IDLE/PLAY/OVER game FSM and OVER-state digit blinking.
// Optional macro SCORE_BEST_EN adds a best-score register shown while IDLE.
//
// state | meaning
// IDLE  | waiting for Start, display holds last (or best) score
// PLAY  | counting Pass pulses until Lose
// OVER  | score frozen, digits blink until Ack
module score_keeper #(
    parameter int MAX_SCORE = 99,
    parameter int BLINK_DIV = 4
) (
    input  logic          Clk,
    input  logic          reset_n,
    score_keeper_if.slave sk
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        PLAY = 3'b010,
        OVER = 3'b100
    } state_t;

    localparam int         CW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [3:0] MAX_TENS  = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_ONES  = 4'(MAX_SCORE % 10);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    state_t        state, state_nxt;
    logic [3:0]    tens, ones, tens_nxt, ones_nxt;
    logic          blank, blank_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          at_max;

    assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

`ifdef SCORE_BEST_EN
    logic [3:0] best_tens, best_ones;

    // Best is captured on the PLAY->OVER edge; strictly greater only.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            best_tens <= 4'd0;
            best_ones <= 4'd0;
        end else if (state == PLAY && sk.Lose && ({tens, ones} > {best_tens, best_ones})) begin
            best_tens <= tens;
            best_ones <= ones;
        end
    end

    assign sk.Best_Tens = best_tens;
    assign sk.Best_Ones = best_ones;
`else
    assign sk.Best_Tens = 4'd0;
    assign sk.Best_Ones = 4'd0;
`endif

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tens  <= 4'd0;
            ones  <= 4'd0;
            blank <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            tens  <= tens_nxt;
            ones  <= ones_nxt;
            blank <= blank_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        tens_nxt  = tens;
        ones_nxt  = ones;
        blank_nxt = 1'b0;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (sk.Start) begin
                    state_nxt = PLAY;
                    tens_nxt  = 4'd0;
                    ones_nxt  = 4'd0;
                end else begin
                    state_nxt = IDLE;
`ifdef SCORE_BEST_EN
                    tens_nxt  = best_tens;
                    ones_nxt  = best_ones;
`endif
                end
            end
            PLAY: begin
                if (sk.Lose) begin
                    state_nxt = OVER;
                end else begin
                    state_nxt = PLAY;
                    if (sk.Pass && !at_max) begin
                        if (ones == 4'd9) begin
                            ones_nxt = 4'd0;
                            tens_nxt = tens + 4'd1;
                        end else begin
                            ones_nxt = ones + 4'd1;
                        end
                    end
                end
            end
            OVER: begin
                if (sk.Ack) begin
                    state_nxt = IDLE;
`ifdef SCORE_BEST_EN
                    tens_nxt  = best_tens;
                    ones_nxt  = best_ones;
`endif
                end else begin
                    state_nxt = OVER;
                    if (cnt == CNT_LAST) begin
                        blank_nxt = ~blank;
                    end else begin
                        blank_nxt = blank;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign sk.Tens   = tens;
    assign sk.Ones   = ones;
    assign sk.Blank  = blank;
    assign sk.Q_Idle = state[0];
    assign sk.Q_Play = state[1];
    assign sk.Q_Over = state[2];
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a behavioural game model pushes the expected outputs
// for every driven cycle; each test pops and compares after the sampling edge.
module tb_score_keeper;
    localparam int MAX_SCORE = 99;
    localparam int BLINK_DIV = 4;
`ifdef SCORE_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif
    localparam logic [19:0] RESET_VEC = 20'h80000;

    logic Clk;
    logic reset_n;
    score_keeper_if sk_if ();

    score_keeper #(.MAX_SCORE(MAX_SCORE), .BLINK_DIV(BLINK_DIV)) dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .sk      (sk_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [19:0] sb[$];
    logic [19:0] exp_v;

    int m_st, m_disp, m_best, m_cnt;
    bit m_blank;

    function automatic logic [19:0] dut_vec();
        return {sk_if.Q_Idle, sk_if.Q_Play, sk_if.Q_Over, sk_if.Blank,
                sk_if.Tens, sk_if.Ones, sk_if.Best_Tens, sk_if.Best_Ones};
    endfunction

    function automatic logic [19:0] model_vec();
        logic [3:0] t, o, bt, bo;
        t  = 4'(m_disp / 10);
        o  = 4'(m_disp % 10);
        bt = 4'(m_best / 10);
        bo = 4'(m_best % 10);
        return {m_st == 0, m_st == 1, m_st == 2, m_blank, t, o, bt, bo};
    endfunction

    task automatic model_reset();
        m_st = 0; m_disp = 0; m_best = 0; m_cnt = 0; m_blank = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input bit st, input bit ack, input bit pas, input bit lose);
        case (m_st)
            0: begin
                if (st) begin m_st = 1; m_disp = 0; end
                else if (BEST_EN) m_disp = m_best;
            end
            1: begin
                if (lose) begin
                    m_st = 2; m_cnt = 0; m_blank = 1'b0;
                    if (BEST_EN && m_disp > m_best) m_best = m_disp;
                end else if (pas && m_disp < MAX_SCORE) begin
                    m_disp++;
                end
            end
            default: begin
                if (ack) begin
                    m_st = 0; m_cnt = 0; m_blank = 1'b0;
                    if (BEST_EN) m_disp = m_best;
                end else if (m_cnt == BLINK_DIV - 1) begin
                    m_cnt = 0; m_blank = !m_blank;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        sb.push_back(model_vec());
    endtask

    // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
    task automatic drive(input bit st, input bit ack, input bit pas, input bit lose);
        sk_if.Start = st; sk_if.Ack = ack; sk_if.Pass = pas; sk_if.Lose = lose;
        model_step(st, ack, pas, lose);
        @(posedge Clk);
        #1;
        sk_if.Start = 1'b0; sk_if.Ack = 1'b0; sk_if.Pass = 1'b0; sk_if.Lose = 1'b0;
    endtask

    task automatic do_reset();
        sk_if.Start = 1'b0; sk_if.Ack = 1'b0; sk_if.Pass = 1'b0; sk_if.Lose = 1'b0;
        @(negedge Clk);
        reset_n = 1'b0;
        model_reset();
        #12;
        @(negedge Clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", dut_vec(), RESET_VEC);
        end
        @(negedge Clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v) begin
            errors++; $display("FAIL reset_idle_hold: got %h want %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_count();
        do_reset();
        drive(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v) begin
            errors++; $display("FAIL count_start: got %h want %h", dut_vec(), exp_v);
        end
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 3; k++) begin
                drive(0, 0, k == 0, 0);
                exp_v = sb.pop_front(); checks++;
                if (dut_vec() !== exp_v) begin
                    errors++; $display("FAIL count_pass%0d: got %h want %h", i, dut_vec(), exp_v);
                end
            end
        end
        checks++;
        if ({sk_if.Q_Play, sk_if.Blank, sk_if.Tens, sk_if.Ones} !== 10'b10_0001_0010) begin
            errors++;
            $display("FAIL count_12: got play=%b blank=%b %h%h want play=1 blank=0 12",
                     sk_if.Q_Play, sk_if.Blank, sk_if.Tens, sk_if.Ones);
        end
    endtask

    task automatic test_bcd_wrap_saturate();
        do_reset();
        drive(1, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (dut_vec() !== exp_v) begin
                errors++; $display("FAIL bcd_step%0d: got %h want %h", i, dut_vec(), exp_v);
            end
        end
        checks++;
        if ({sk_if.Tens, sk_if.Ones} !== 8'h09) begin
            errors++; $display("FAIL bcd_09: got %h%h want 09", sk_if.Tens, sk_if.Ones);
        end
        drive(0, 0, 1, 0);
        void'(sb.pop_front());
        checks++;
        if ({sk_if.Tens, sk_if.Ones} !== 8'h10) begin
            errors++; $display("FAIL bcd_wrap_10: got %h%h want 10", sk_if.Tens, sk_if.Ones);
        end
        for (int i = 0; i < 92; i++) begin
            drive(0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (dut_vec() !== exp_v) begin
                errors++; $display("FAIL sat_step%0d: got %h want %h", i, dut_vec(), exp_v);
            end
        end
        checks++;
        if ({sk_if.Tens, sk_if.Ones} !== 8'h99) begin
            errors++; $display("FAIL saturate_99: got %h%h want 99", sk_if.Tens, sk_if.Ones);
        end
    endtask

    task automatic test_pass_lose_blink();
        bit blank_pat[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        drive(1, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            void'(sb.pop_front());
        end
        drive(0, 0, 1, 1);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v) begin
            errors++; $display("FAIL pass_lose_model: got %h want %h", dut_vec(), exp_v);
        end
        checks++;
        if ({sk_if.Q_Over, sk_if.Blank, sk_if.Tens, sk_if.Ones} !== 10'b10_0000_0101) begin
            errors++;
            $display("FAIL pass_lose: got over=%b blank=%b %h%h want over=1 blank=0 05",
                     sk_if.Q_Over, sk_if.Blank, sk_if.Tens, sk_if.Ones);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, (i == 2), 0);
            exp_v = sb.pop_front(); checks++;
            if (dut_vec() !== exp_v) begin
                errors++; $display("FAIL blink_model%0d: got %h want %h", i, dut_vec(), exp_v);
            end
            checks++;
            if (sk_if.Blank !== blank_pat[i]) begin
                errors++; $display("FAIL blink_pat%0d: got %b want %b", i, sk_if.Blank, blank_pat[i]);
            end
        end
        drive(1, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v) begin
            errors++; $display("FAIL ack_start_model: got %h want %h", dut_vec(), exp_v);
        end
        checks++;
        if ({sk_if.Q_Idle, sk_if.Blank, sk_if.Tens, sk_if.Ones} !== 10'b10_0000_0101) begin
            errors++;
            $display("FAIL ack_start: got idle=%b blank=%b %h%h want idle=1 blank=0 05",
                     sk_if.Q_Idle, sk_if.Blank, sk_if.Tens, sk_if.Ones);
        end
        drive(0, 0, 1, 1);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v || sk_if.Q_Idle !== 1'b1) begin
            errors++; $display("FAIL idle_ignores: got %h want %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_play_ignores_start();
        do_reset();
        drive(1, 0, 0, 0);
        void'(sb.pop_front());
        drive(0, 0, 1, 0);
        void'(sb.pop_front());
        drive(1, 0, 1, 0);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v || {sk_if.Tens, sk_if.Ones} !== 8'h02) begin
            errors++; $display("FAIL play_start_ignored: got %h want %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 0);
            void'(sb.pop_front());
        end
        checks++;
        if ({sk_if.Tens, sk_if.Ones} !== 8'h07) begin
            errors++; $display("FAIL async_pre7: got %h%h want 07", sk_if.Tens, sk_if.Ones);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++; $display("FAIL async_reset: got %h want %h", dut_vec(), RESET_VEC);
        end
        model_reset();
        #2 reset_n = 1'b1;
        drive(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (dut_vec() !== exp_v || sk_if.Q_Idle !== 1'b1) begin
            errors++; $display("FAIL async_release: got %h want %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_best();
        logic [7:0] want_disp, want_best;
        int scores[2] = '{8, 3};
        do_reset();
        for (int g = 0; g < 2; g++) begin
            drive(1, 0, 0, 0);
            void'(sb.pop_front());
            for (int i = 0; i < scores[g]; i++) begin
                drive(0, 0, 1, 0);
                void'(sb.pop_front());
            end
            drive(0, 0, 0, 1);
            exp_v = sb.pop_front(); checks++;
            if (dut_vec() !== exp_v) begin
                errors++; $display("FAIL best_lose%0d: got %h want %h", g, dut_vec(), exp_v);
            end
            drive(0, 1, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (dut_vec() !== exp_v) begin
                errors++; $display("FAIL best_ack%0d: got %h want %h", g, dut_vec(), exp_v);
            end
        end
        drive(0, 0, 0, 0);
        void'(sb.pop_front());
        want_disp = BEST_EN ? 8'h08 : 8'h03;
        want_best = BEST_EN ? 8'h08 : 8'h00;
        checks++;
        if ({sk_if.Tens, sk_if.Ones, sk_if.Best_Tens, sk_if.Best_Ones} !== {want_disp, want_best}) begin
            errors++;
            $display("FAIL best_idle: got show=%h%h best=%h%h want show=%h best=%h",
                     sk_if.Tens, sk_if.Ones, sk_if.Best_Tens, sk_if.Best_Ones, want_disp, want_best);
        end
    endtask

    initial begin
        sk_if.Start = 1'b0; sk_if.Ack = 1'b0; sk_if.Pass = 1'b0; sk_if.Lose = 1'b0;
        test_reset();
        test_count();
        test_bcd_wrap_saturate();
        test_pass_lose_blink();
        test_play_ignores_start();
        test_async_reset();
        test_best();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
